xbar_sched: RTL and testbench
=============================

# xbar_sched

Per-slot destination arbiter and mux configurator for the 8x8 serial crossbar. At each header phase it takes the eight deserialised 8-bit headers, validates them, and resolves output-port contention with an independent round-robin pointer per output. It drives the crossbar's per-output source-select and per-input grant for the following payload phase. It also maintains the 4-entry time-slot counter that headers are checked against.

## Interface
- PORTS, 8, number of input and output ports (select width is log2(PORTS) = 3).
- SLOTS, 4, time slots per frame (slot field width is 2).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- hdr_strobe  in  1  one-cycle pulse; `hdr` holds all headers for the current slot.
- hdr  in  PORTS*8  header of input i at bits [8i+7:8i].
  - [7] start: 1 = request, 0 = idle.
  - [6:4] destination port.
  - [3:2] slot.
  - [1] reserved, must be 0.
  - [0] parity, equal to ~^[7:1] (odd parity over all 8 bits).
- sel  out  PORTS*3  source input for output o at [3o+2:3o].
- sel_valid  out  PORTS  output o has a granted source.
- grant  out  PORTS  input i won its destination.
- hdr_err  out  PORTS  one-cycle pulse per input whose header was rejected.
- done  out  1  one-cycle pulse when sel/grant update.
- overrun  out  1  one-cycle pulse when a strobe is ignored.
- slot  out  2  current slot counter.

## Operation
- Three-stage pipeline.
  - S0: capture `hdr` on `hdr_strobe`.
  - S1: validate headers and build the request matrix.
  - S2: arbitrate and register outputs.
- Header from input i is a valid request if all of the following hold:
  - start = 1;
  - reserved = 0;
  - slot field equals `slot`;
  - parity is correct (only when `XBAR_SCHED_PARITY_EN` is defined).
- A header with start = 1 that fails any check pulses hdr_err[i] and makes no request.
- A header with start = 0 is idle: no request and no error.
- Arbitration, independently per output o:
  - candidates are the valid requesters whose dest = o;
  - the winner is the first candidate at index >= ptr[o], searching upward with wrap 7→0;
  - ptr[o] <= winner+1 (mod 8) only when o had at least one candidate, otherwise unchanged.
- Outputs:
  - sel[o] = winner and sel_valid[o] = 1;
  - if o has no candidates, sel[o] = 0 and sel_valid[o] = 0;
  - grant[i] = 1 iff i won.
- Losers get no grant. They are not queued and must re-request in a later frame.
- sel, sel_valid and grant hold until the next `done`.
- `slot` increments (wrapping 3→0) in the same cycle `done` pulses, so the next header phase is checked against the next slot.

## Timing
- The strobe is sampled at edge T. At T+1 the request matrix is registered.
- At T+2 the following update together: sel, sel_valid, grant, hdr_err, done and slot.
- Latency is strobe → done = 2 cycles.
- A strobe at T+1, while the pipeline is busy, is ignored: overrun pulses at T+2 and state is unaffected. A strobe at T+2 or later is accepted.
- Reset values, applied immediately on rst assertion:
  - sel, sel_valid, grant, hdr_err, done, overrun = 0;
  - slot = 0;
  - all ptr = 0;
  - pipeline valid flags cleared.
- A reset mid-pipeline discards the in-flight frame: no done is produced after rst deasserts.
- Simultaneous done and an accepted strobe: both occur. The new frame is validated against the already-incremented slot.

## Configuration
- `XBAR_SCHED_PARITY_EN` defined: a header with a parity error (^hdr[7:0] != 1) is rejected with hdr_err.
- Not defined: the parity bit is ignored and no parity logic is compiled in. All other checks are unchanged.

## Test plan
- Identity mapping: slot 0, input i sends {1,i,00,0,p} for all i → at T+2 sel[o] = o, sel_valid = 8'hFF, grant = 8'hFF, hdr_err = 0, slot = 1.
- Hotspot: all inputs send 8'hB0 (dest 3, slot 0) for 8 frames, with slot re-synced by resetting the slot field each frame → sel[3] = 0,1,…,7 in successive frames, exactly one grant per frame, other outputs' sel_valid = 0.
- Parity error with `XBAR_SCHED_PARITY_EN` defined: input 2 sends 8'hB1, input 5 sends 8'hB0 → hdr_err = 8'h04, sel[3] = 5, grant = 8'h20. Without the macro: sel[3] = 2 (ptr = 0), no error.
- Slot mismatch: slot = 0, input 1 sends a header with slot = 1 → hdr_err[1] = 1, grant[1] = 0. Idle headers (8'h00) → no error, no grant.
- Overrun: strobes at T and T+1 → a single done at T+2, overrun = 1 at T+2, slot advances by 1 only.
- Async reset asserted at T+1 after a valid strobe → all outputs 0 within the same cycle. After release, no done pulses and slot = 0.

Source files
------------

// File: rtl/xbar_sched.sv
// Header arbiter and mux configurator for the 8x8 serial crossbar: 3-stage capture/validate/arbitrate pipeline.
// Define XBAR_SCHED_PARITY_EN to reject headers with bad odd parity; otherwise the parity bit is ignored.
module xbar_sched #(
  parameter int PORTS = 8,
  parameter int SLOTS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               hdr_strobe,
  input  logic [PORTS*8-1:0]                 hdr,
  output logic [PORTS*$clog2(PORTS)-1:0]     sel,
  output logic [PORTS-1:0]                   sel_valid,
  output logic [PORTS-1:0]                   grant,
  output logic [PORTS-1:0]                   hdr_err,
  output logic                               done,
  output logic                               overrun,
  output logic [$clog2(SLOTS)-1:0]           slot
);
  localparam int SW = $clog2(PORTS);
  localparam int TW = $clog2(SLOTS);
  localparam logic [TW-1:0] SLOT_LAST = TW'(SLOTS - 1);

  // S0: header capture
  logic               v0;
  logic               ovr_p;
  logic [PORTS*8-1:0] s0_hdr;

  // S1: request matrix
  logic               v1;
  logic [PORTS-1:0]   req1;
  logic [PORTS-1:0]   err1;
  logic [SW-1:0]      dest1 [PORTS];
  logic [PORTS-1:0]   req_n;
  logic [PORTS-1:0]   err_n;
  logic [SW-1:0]      dest_n [PORTS];

  // S2: arbitration
  logic [SW-1:0]      ptr   [PORTS];
  logic [SW-1:0]      ptr_n [PORTS];
  logic [PORTS*SW-1:0] sel_n;
  logic [PORTS-1:0]   selv_n;
  logic [PORTS-1:0]   grant_n;

  // Only S0 occupancy blocks a new strobe; a strobe landing on the done edge is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0     <= 1'b0;
      ovr_p  <= 1'b0;
      s0_hdr <= '0;
    end else begin
      v0    <= hdr_strobe & ~v0;
      ovr_p <= hdr_strobe & v0;
      if (hdr_strobe && !v0)
        s0_hdr <= hdr;
    end
  end

  always_comb begin
    logic [7:0] h;
    logic       ok;
    h     = '0;
    ok    = 1'b0;
    req_n = '0;
    err_n = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      h  = s0_hdr[8*i +: 8];
      ok = h[7] & ~h[1] & (h[3:2] == slot);
`ifdef XBAR_SCHED_PARITY_EN
      ok = ok & (^h);
`endif
      dest_n[i] = h[6:4];
      req_n[i]  = ok;
      err_n[i]  = h[7] & ~ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      req1  <= '0;
      err1  <= '0;
      dest1 <= '{default: '0};
    end else begin
      v1 <= v0;
      if (v0) begin
        req1  <= req_n;
        err1  <= err_n;
        dest1 <= dest_n;
      end
    end
  end

  // Per-output round-robin: first candidate at or above ptr, wrapping.
  always_comb begin
    logic        found;
    int unsigned idx;
    found   = 1'b0;
    idx     = 0;
    sel_n   = '0;
    selv_n  = '0;
    grant_n = '0;
    ptr_n   = ptr;
    for (int unsigned o = 0; o < PORTS; o++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < PORTS; k++) begin
        idx = (32'(ptr[o]) + k) % PORTS;
        if (!found && req1[idx] && dest1[idx] == SW'(o)) begin
          found              = 1'b1;
          sel_n[o*SW +: SW]  = SW'(idx);
          selv_n[o]          = 1'b1;
          grant_n[idx]       = 1'b1;
          ptr_n[o]           = SW'((idx + 1) % PORTS);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      sel_valid <= '0;
      grant     <= '0;
      hdr_err   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      slot      <= '0;
      ptr       <= '{default: '0};
    end else begin
      done    <= v1;
      overrun <= ovr_p;
      hdr_err <= v1 ? err1 : '0;
      if (v1) begin
        sel       <= sel_n;
        sel_valid <= selv_n;
        grant     <= grant_n;
        ptr       <= ptr_n;
        slot      <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_xbar_sched.sv
// Scoreboard bench for xbar_sched: directed frames push expected outputs, a negedge monitor checks each done.
module tb_xbar_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hdr_strobe = 1'b0;
  logic [63:0] hdr = '0;
  logic [23:0] sel;
  logic [7:0]  sel_valid;
  logic [7:0]  grant;
  logic [7:0]  hdr_err;
  logic        done;
  logic        overrun;
  logic [1:0]  slot;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [23:0] sel;
    logic [7:0]  selv;
    logic [7:0]  grant;
    logic [7:0]  err;
    logic [1:0]  slot;
  } exp_t;

  exp_t q[$];

  xbar_sched #(.PORTS(8), .SLOTS(4)) dut (
    .clk(clk), .rst(rst), .hdr_strobe(hdr_strobe), .hdr(hdr),
    .sel(sel), .sel_valid(sel_valid), .grant(grant), .hdr_err(hdr_err),
    .done(done), .overrun(overrun), .slot(slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Odd parity over all 8 bits.
  function automatic logic [7:0] mkhdr(input logic st, input logic [2:0] dst,
                                       input logic [1:0] sl, input logic rsv);
    logic [7:0] h;
    h = {st, dst, sl, rsv, 1'b0};
    h[0] = ~^h[7:1];
    return h;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sel", 32'(sel), 32'(e.sel));
        check("sel_valid", 32'(sel_valid), 32'(e.selv));
        check("grant", 32'(grant), 32'(e.grant));
        check("hdr_err", 32'(hdr_err), 32'(e.err));
        check("slot", 32'(slot), 32'(e.slot));
      end
    end
  end

  task automatic send(input logic [63:0] h, input exp_t e);
    @(negedge clk);
    hdr        = h;
    hdr_strobe = 1'b1;
    q.push_back(e);
    @(negedge clk);
    hdr_strobe = 1'b0;
    hdr        = '0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
    check(name, 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] hv;
    exp_t e;

    do_reset();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_sel_valid", 32'(sel_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_hdr_err", 32'(hdr_err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);

    // Identity: input i -> output i.
    hv = '0;
    for (int i = 0; i < 8; i++) hv[8*i +: 8] = mkhdr(1'b1, 3'(i), 2'd0, 1'b0);
    e.sel = 24'b111_110_101_100_011_010_001_000;
    e.selv = 8'hFF; e.grant = 8'hFF; e.err = 8'h00; e.slot = 2'd1;
    send(hv, e);
    drain("identity_drain");

    // Hotspot: all to output 3, back-to-back frames, slot field tracking the counter.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      hv = '0;
      for (int i = 0; i < 8; i++) hv[8*i +: 8] = mkhdr(1'b1, 3'd3, 2'(k % 4), 1'b0);
      e.sel = 24'(k) << 9;
      e.selv = 8'h08; e.grant = 8'(1 << k); e.err = 8'h00; e.slot = 2'((k + 1) % 4);
      send(hv, e);
    end
    drain("hotspot_drain");

    // Parity: input 2 sends B1 (even parity), input 5 sends B0.
    do_reset();
    hv = '0;
    hv[8*2 +: 8] = 8'hB1;
    hv[8*5 +: 8] = 8'hB0;
`ifdef XBAR_SCHED_PARITY_EN
    e.sel = 24'd5 << 9; e.grant = 8'h20; e.err = 8'h04;
`else
    e.sel = 24'd2 << 9; e.grant = 8'h04; e.err = 8'h00;
`endif
    e.selv = 8'h08; e.slot = 2'd1;
    send(hv, e);
    drain("parity_drain");

    // Slot mismatch on input 1, reserved bit on input 2, valid on input 0, then an idle frame.
    do_reset();
    hv = '0;
    hv[8*0 +: 8] = mkhdr(1'b1, 3'd0, 2'd0, 1'b0);
    hv[8*1 +: 8] = mkhdr(1'b1, 3'd0, 2'd1, 1'b0);
    hv[8*2 +: 8] = mkhdr(1'b1, 3'd2, 2'd0, 1'b1);
    e.sel = '0; e.selv = 8'h01; e.grant = 8'h01; e.err = 8'h06; e.slot = 2'd1;
    send(hv, e);
    e.sel = '0; e.selv = 8'h00; e.grant = 8'h00; e.err = 8'h00; e.slot = 2'd2;
    send(64'h0, e);
    drain("mismatch_drain");

    // Strobe on the done edge: second frame must see the incremented slot.
    do_reset();
    e.sel = '0; e.selv = 8'h01; e.grant = 8'h01; e.err = 8'h00; e.slot = 2'd1;
    send({56'h0, mkhdr(1'b1, 3'd0, 2'd0, 1'b0)}, e);
    e.slot = 2'd2;
    send({56'h0, mkhdr(1'b1, 3'd0, 2'd1, 1'b0)}, e);
    drain("b2b_drain");

    // Overrun: strobes at T and T+1.
    do_reset();
    @(negedge clk);
    hdr = {56'h0, mkhdr(1'b1, 3'd0, 2'd0, 1'b0)};
    hdr_strobe = 1'b1;
    e.sel = '0; e.selv = 8'h01; e.grant = 8'h01; e.err = 8'h00; e.slot = 2'd1;
    q.push_back(e);
    @(negedge clk);
    hdr = {48'h0, mkhdr(1'b1, 3'd1, 2'd0, 1'b0), 8'h00};
    @(negedge clk);
    hdr_strobe = 1'b0;
    hdr = '0;
    check("ovr_before", 32'(overrun), 32'd0);
    @(negedge clk);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_done", 32'(done), 32'd1);
    @(negedge clk);
    check("ovr_clear", 32'(overrun), 32'd0);
    drain("ovr_drain");
    repeat (3) @(negedge clk);
    check("ovr_slot", 32'(slot), 32'd1);

    // Async reset mid-pipeline with non-zero outputs standing.
    @(negedge clk);
    hdr = {56'h0, mkhdr(1'b1, 3'd4, 2'd1, 1'b0)};
    hdr_strobe = 1'b1;
    @(negedge clk);
    hdr_strobe = 1'b0;
    hdr = '0;
    rst = 1'b1;
    #1;
    check("arst_sel_valid", 32'(sel_valid), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_slot", 32'(slot), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("arst_slot_after", 32'(slot), 32'd0);
    check("arst_selv_after", 32'(sel_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
